// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and limits for the truth-table sequencer and its hold timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_sequencer_pkg;

   // FSM state encodings
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } tt_state_e;

   // Legal range of the per-vector hold length, bounded by the 16-bit timer
   localparam int TT_HOLD_MIN = 1;
   localparam int TT_HOLD_MAX = 65535;
   localparam int TT_TIMER_W  = 16;

   // Truth-table width for an n-input function
   function automatic int tt_table_w(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Down-counter that paces how long each input vector is held.
// Latency: zero flag is registered-state combinational; a load takes effect on the next edge.
// Backpressure: none; load has priority over counting, counter parks at zero.
module hold_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] r_cnt;

   // Load or count down, stopping at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks all 2**N_IN input vectors, holds each HOLD_CYCLES, samples f and scores it against exp_table.
// Latency: busy for 2**N_IN*HOLD_CYCLES+1 cycles after start; done pulses in the last of them.
// Backpressure: start is only honoured in IDLE and never queued. Optional macro TT_FIRST_FAIL_EN adds first_fail/first_fail_vld.
module truth_table_sequencer
   import truth_table_sequencer_pkg::*;
#(
   parameter int N_IN        = 3,
   parameter int HOLD_CYCLES = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [(1<<N_IN)-1:0]  exp_table,
   output logic [N_IN-1:0]       x,
   input  logic                  f,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [(1<<N_IN)-1:0]  captured,
   output logic [N_IN:0]         err_count
`ifdef TT_FIRST_FAIL_EN
   ,
   output logic [N_IN-1:0]       first_fail,
   output logic                  first_fail_vld
`endif
);

   localparam int TW = tt_table_w(N_IN);

   // Out-of-range hold lengths are pinned to the nearest legal value
   localparam int HOLD_EFF = (HOLD_CYCLES < TT_HOLD_MIN) ? TT_HOLD_MIN :
                             (HOLD_CYCLES > TT_HOLD_MAX) ? TT_HOLD_MAX : HOLD_CYCLES;
   localparam logic [TT_TIMER_W-1:0] LOAD_VAL = TT_TIMER_W'(HOLD_EFF - 1);

   tt_state_e          r_state;
   tt_state_e          w_state_nxt;

   logic [N_IN-1:0]    r_x;
   logic [TW-1:0]      r_exp;
   logic [TW-1:0]      r_captured;
   logic [N_IN:0]      r_err;
   logic               r_pass;

   logic               w_accept;
   logic               w_sample;
   logic               w_tmr_load;
   logic               w_tmr_zero;
   logic               w_last;
   logic               w_mismatch;
   logic [N_IN:0]      w_err_nxt;

   assign w_last     = (r_x == {N_IN{1'b1}});
   assign w_mismatch = (f != r_exp[r_x]);
   assign w_err_nxt  = r_err + {{N_IN{1'b0}}, w_mismatch};

   hold_timer #(
      .W        (TT_TIMER_W)
   ) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (LOAD_VAL),
      .zero     (w_tmr_zero)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, strobes and status outputs
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      w_tmr_load  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_tmr_load  = 1'b1;
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            busy = 1'b1;
            if (w_tmr_zero) begin
               w_sample = 1'b1;
               if (w_last) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_tmr_load = 1'b1;
               end
            end
         end
         ST_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Vector walk, capture and scoring; pass is resolved on the final sample edge
   // so it already reflects the last vector while done is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x        <= '0;
         r_exp      <= '0;
         r_captured <= '0;
         r_err      <= '0;
         r_pass     <= 1'b0;
      end else if (w_accept) begin
         r_x        <= '0;
         r_exp      <= exp_table;
         r_captured <= '0;
         r_err      <= '0;
         r_pass     <= 1'b0;
      end else if (w_sample) begin
         r_captured[r_x] <= f;
         r_err           <= w_err_nxt;
         if (w_last) begin
            r_x    <= '0;
            r_pass <= (w_err_nxt == '0);
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

`ifdef TT_FIRST_FAIL_EN
   logic [N_IN-1:0] r_first_fail;
   logic            r_first_fail_vld;

   // Remember the lowest mismatching vector of the current run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_first_fail     <= '0;
         r_first_fail_vld <= 1'b0;
      end else if (w_accept) begin
         r_first_fail     <= '0;
         r_first_fail_vld <= 1'b0;
      end else if (w_sample && w_mismatch && !r_first_fail_vld) begin
         r_first_fail     <= r_x;
         r_first_fail_vld <= 1'b1;
      end
   end

   assign first_fail     = r_first_fail;
   assign first_fail_vld = r_first_fail_vld;
`endif

   assign x         = r_x;
   assign captured  = r_captured;
   assign err_count = r_err;
   assign pass      = r_pass;

endmodule
